// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit common-anode 7-segment driver with per-slot anti-ghost blanking and frame-atomic BCD capture.
// Optional build macro SEG_LZ_BLANK_EN enables leading-zero blanking of digits 3..1.
module seg7_scan_driver #(
    parameter int CLK_DIV   = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] bcd,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam logic [23:0] DIV_MAX   = 24'(CLK_DIV - 1);
    localparam logic [23:0] BLANK_LIM = 24'(BLANK_CYC);

    logic [23:0] div_q, div_d;
    logic [1:0]  digit_q, digit_d;
    logic [15:0] shadow_bcd_q, shadow_bcd_d;
    logic [3:0]  shadow_dp_q, shadow_dp_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic        frame_done_q, frame_done_d;
    logic        tick_s;
    logic [3:0]  nibble_s;
    logic [6:0]  glyph_s;

    // Active-low a..g pattern; anything outside 0..9 renders as a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111110;
        endcase
        return s;
    endfunction

`ifdef SEG_LZ_BLANK_EN
    // A digit is a leading zero when it and every more significant nibble are zero; digit 0 always shows.
    function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] d);
        logic b;
        case (d)
            2'd1:    b = (v[15:4] == 12'd0);
            2'd2:    b = (v[15:8] == 8'd0);
            2'd3:    b = (v[15:12] == 4'd0);
            default: b = 1'b0;
        endcase
        return b;
    endfunction
`endif

    // Divider, digit index, frame capture and next-state output patterns.
    always_comb begin
        tick_s       = (div_q == DIV_MAX);
        div_d        = tick_s ? 24'd0 : div_q + 24'd1;
        digit_d      = tick_s ? digit_q + 2'd1 : digit_q;
        shadow_bcd_d = shadow_bcd_q;
        shadow_dp_d  = shadow_dp_q;
        frame_done_d = 1'b0;
        if (tick_s && (digit_q == 2'd3)) begin
            shadow_bcd_d = bcd;
            shadow_dp_d  = dp_in;
            frame_done_d = 1'b1;
        end else begin
            frame_done_d = 1'b0;
        end

        case (digit_q)
            2'd0:    nibble_s = shadow_bcd_q[3:0];
            2'd1:    nibble_s = shadow_bcd_q[7:4];
            2'd2:    nibble_s = shadow_bcd_q[11:8];
            2'd3:    nibble_s = shadow_bcd_q[15:12];
            default: nibble_s = 4'd0;
        endcase

`ifdef SEG_LZ_BLANK_EN
        glyph_s = lz_blank(shadow_bcd_q, digit_q) ? 7'b1111111 : seg_decode(nibble_s);
`else
        glyph_s = seg_decode(nibble_s);
`endif

        // Segments and dp track the slot even while anodes are blanked.
        if (!en) begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
            dp_d  = 1'b1;
        end else begin
            an_d  = (div_q < BLANK_LIM) ? 4'b1111 : ~(4'b0001 << digit_q);
            seg_d = glyph_s;
            dp_d  = ~shadow_dp_q[digit_q];
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= 24'd0;
            digit_q      <= 2'd0;
            shadow_bcd_q <= 16'd0;
            shadow_dp_q  <= 4'd0;
            an_q         <= 4'b1111;
            seg_q        <= 7'b1111111;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            digit_q      <= digit_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_dp_q  <= shadow_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (CLK_DIV=4, BLANK_CYC=1) with a cycle-count based reference model.
module tb_seg7_scan_driver;

    localparam int CD  = 4;
    localparam int BC  = 1;
    localparam int SLOT_FRAME = 4 * CD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [15:0] bcd = 16'h1234;
    logic [3:0]  dp_in = 4'b0000;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(.CLK_DIV(CD), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .bcd(bcd), .dp_in(dp_in),
        .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16];
    initial begin
        glyph[0] = 7'b0000001; glyph[1] = 7'b1001111; glyph[2] = 7'b0010010; glyph[3] = 7'b0000110;
        glyph[4] = 7'b1001100; glyph[5] = 7'b0100100; glyph[6] = 7'b0100000; glyph[7] = 7'b0001111;
        glyph[8] = 7'b0000000; glyph[9] = 7'b0000100;
        for (int i = 10; i < 16; i++) glyph[i] = 7'b1111110;
    end

    // Model: n = clock edges since reset release; slot position and digit follow from plain arithmetic.
    int          n;
    logic [15:0] m_bcd;
    logic [3:0]  m_dp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;

    always @(posedge clk or negedge rst_n) begin
        int pos, dig, nib;
        if (!rst_n) begin
            n <= 0; m_bcd <= 16'h0; m_dp <= 4'h0;
            e_an <= 4'b1111; e_seg <= 7'b1111111; e_dp <= 1'b1; e_fd <= 1'b0;
        end else begin
            pos = n % CD;
            dig = (n / CD) % 4;
            nib = (m_bcd >> (4 * dig)) & 16'hF;
            if (en) begin
                e_an  <= (pos < BC) ? 4'b1111 : 4'(~(1 << dig));
`ifdef SEG_LZ_BLANK_EN
                e_seg <= (dig > 0 && (m_bcd >> (4 * dig)) == 16'h0) ? 7'b1111111 : glyph[nib];
`else
                e_seg <= glyph[nib];
`endif
                e_dp  <= ~m_dp[dig];
            end else begin
                e_an <= 4'b1111; e_seg <= 7'b1111111; e_dp <= 1'b1;
            end
            e_fd <= (n % SLOT_FRAME) == (SLOT_FRAME - 1);
            if ((n % SLOT_FRAME) == (SLOT_FRAME - 1)) begin
                m_bcd <= bcd;
                m_dp  <= dp_in;
            end
            n <= n + 1;
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (n=%0d)", name, got, exp, n);
        end
    endtask

    // Continuous compare against the model on every falling edge.
    always @(negedge clk) begin
        chk("model_an",  {12'd0, an},  {12'd0, e_an});
        chk("model_seg", {9'd0, seg},  {9'd0, e_seg});
        chk("model_dp",  {15'd0, dp},  {15'd0, e_dp});
        chk("model_fd",  {15'd0, frame_done}, {15'd0, e_fd});
    end

    // Advance to the falling edge after edge number target; outputs then show state target-1.
    task automatic goto(input int target);
        int guard;
        guard = 0;
        while (n < target && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (n != target) begin
            errors++;
            $display("FAIL goto: reached n=%0d expected %0d", n, target);
        end
    endtask

    task automatic slot(input string name, input int target, input logic [3:0] a, input logic [6:0] s, input logic d);
        goto(target);
        chk({name, "_an"},  {12'd0, a ^ an ^ a}, {12'd0, a});
        chk({name, "_seg"}, {9'd0, seg}, {9'd0, s});
        chk({name, "_dp"},  {15'd0, dp},  {15'd0, d});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_an",  {12'd0, an},  16'h000F);
        chk("reset_seg", {9'd0, seg},  16'h007F);
        chk("reset_dp",  {15'd0, dp},  16'h0001);
        chk("reset_fd",  {15'd0, frame_done}, 16'h0000);
        rst_n = 1'b1;

        // First frame shows the zero shadow; second frame shows 1234.
        slot("f0_d0", 2, 4'b1110, 7'b0000001, 1'b1);
        slot("f0_d3", 14, 4'b0111, 7'b0000001, 1'b1);
        slot("f1_d0", 18, 4'b1110, 7'b1001100, 1'b1);
        slot("f1_d3", 30, 4'b0111, 7'b1001111, 1'b1);
        goto(33);
        chk("blank_slot_an", {12'd0, an}, 16'h000F);
        goto(48);
        chk("fd_pulse", {15'd0, frame_done}, 16'h0001);
        goto(49);
        chk("fd_low", {15'd0, frame_done}, 16'h0000);

        // Mid-frame change is deferred to the next frame.
        goto(53);
        bcd = 16'h9876;
        slot("tear_d2", 58, 4'b1011, 7'b0010010, 1'b1);
        slot("tear_d3", 62, 4'b0111, 7'b1001111, 1'b1);
        slot("new_d0", 66, 4'b1110, 7'b0100000, 1'b1);
        slot("new_d1", 70, 4'b1101, 7'b0001111, 1'b1);
        slot("new_d2", 74, 4'b1011, 7'b0000000, 1'b1);
        slot("new_d3", 78, 4'b0111, 7'b0000100, 1'b1);

        // Illegal nibbles and decimal point.
        goto(79);
        bcd = 16'hA0F5; dp_in = 4'b0100;
        slot("ill_d0", 82, 4'b1110, 7'b0100100, 1'b1);
        slot("ill_d1", 86, 4'b1101, 7'b1111110, 1'b1);
        slot("ill_d2", 90, 4'b1011, 7'b0000001, 1'b0);
        slot("ill_d3", 94, 4'b0111, 7'b1111110, 1'b1);

        // Enable low: blanked outputs, frame_done keeps its period.
        goto(95);
        en = 1'b0;
        slot("en0", 96, 4'b1111, 7'b1111111, 1'b1);
        chk("en0_fd", {15'd0, frame_done}, 16'h0001);
        goto(105);
        en = 1'b1;

        // Async reset in the digit 2 slot, checked before any clock edge.
        slot("pre_rst_d2", 122, 4'b1011, 7'b0000001, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an",  {12'd0, an},  16'h000F);
        chk("async_seg", {9'd0, seg},  16'h007F);
        chk("async_dp",  {15'd0, dp},  16'h0001);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bcd = 16'h0045; dp_in = 4'b0000;
        slot("restart_d0", 2, 4'b1110, 7'b0000001, 1'b1);

        // Leading zeros.
        slot("lz_d0", 18, 4'b1110, 7'b0100100, 1'b1);
        slot("lz_d1", 22, 4'b1101, 7'b1001100, 1'b1);
`ifdef SEG_LZ_BLANK_EN
        slot("lz_d2", 26, 4'b1011, 7'b1111111, 1'b1);
        slot("lz_d3", 30, 4'b0111, 7'b1111111, 1'b1);
`else
        slot("lz_d2", 26, 4'b1011, 7'b0000001, 1'b1);
        slot("lz_d3", 30, 4'b0111, 7'b0000001, 1'b1);
`endif
        bcd = 16'h0000;
        slot("zero_d0", 34, 4'b1110, 7'b0000001, 1'b1);
`ifdef SEG_LZ_BLANK_EN
        slot("zero_d1", 38, 4'b1101, 7'b1111111, 1'b1);
`else
        slot("zero_d1", 38, 4'b1101, 7'b0000001, 1'b1);
`endif
        goto(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Consumes the 4-digit packed BCD word from the binary-to-BCD converter and drives a common-anode 4-digit multiplexed 7-segment display. A refresh divider scans the digits one at a time. Anti-ghosting blanking is applied at each digit switch. BCD input is sampled once per frame, so a displayed frame is never torn.

Parameters:
CLK_DIV, 100000, clk cycles per digit slot; legal range 2..2^24-1.
BLANK_CYC, 16, cycles at the start of each slot with all anodes off; must be < CLK_DIV.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
en  input  1  display enable; 0 blanks all outputs while the counters keep running
bcd  input  16  packed BCD; [3:0] is digit 0 (rightmost), [15:12] is digit 3
dp_in  input  4  per-digit decimal point request, active-high; bit i belongs to digit i
an  output  4  digit anodes, active-low, registered
seg  output  7  segments, active-low, registered; seg[6]=a, seg[5]=b, … seg[0]=g
dp  output  1  decimal point, active-low, registered
frame_done  output  1  1-cycle pulse at each frame boundary

Behaviour:
- Reset (async, rst_n=0):
  - div_cnt=0, digit=0.
  - Shadow bcd = 0, shadow dp = 0.
  - an=4'b1111, seg=7'b1111111, dp=1, frame_done=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and then wraps to 0.
  - The wrap cycle is the "tick".
- Digit index:
  - On each tick, digit advances 0→1→2→3→0.
- Frame capture:
  - On a tick with digit==3, shadow_bcd<=bcd and shadow_dp<=dp_in, in the same edge as digit→0.
  - frame_done=1 for that cycle (registered, so visible in the following cycle).
  - First frame after reset displays the shadow reset values (0000).
- Blanking:
  - While div_cnt < BLANK_CYC, the next-state an=4'b1111.
  - Otherwise an = one-hot-low of digit (digit 0 → 4'b1110, digit 3 → 4'b0111).
- Segment decode of shadow nibble `digit` (active-low, a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Nibbles 10–15 are illegal BCD and show a dash: 1111110.
- dp output = ~shadow_dp[digit].
- Latency: an/seg/dp are registered and reflect div_cnt/digit state with 1-cycle latency. seg and dp are updated every cycle, including during blanking.
- en=0:
  - Next-state an=1111, seg=1111111, dp=1.
  - The divider, digit index and frame capture continue unaffected.
  - frame_done still pulses.
- Changes on bcd mid-frame have no visible effect until the next frame boundary.
- Reset asserted mid-scan returns immediately (asynchronously) to the reset values; scanning restarts at digit 0, div_cnt 0.

Optional Feature:
SEG_LZ_BLANK_EN
- Defined: leading-zero blanking.
  - Digit i (i=3,2,1) is blanked (seg=1111111) when shadow nibbles i..3 are all 0.
  - Digit 0 is never blanked.
  - an still scans normally.
  - dp still follows shadow_dp, even on blanked digits.
  - Evaluation uses the shadow register only.
- Undefined: all digits always decoded; zeros shown as "0".

Test Plan:
All scenarios use CLK_DIV=4, BLANK_CYC=1.
1. Reset and first frames: assert rst_n=0, release, hold bcd=16'h1234.
   → Reset outputs are an=1111/seg=1111111/dp=1.
   → First frame shows 0 on every digit (seg=0000001).
   → In the second frame, digit 0 slot shows an=1110, seg=1001100 ("4"); digit 3 slot shows an=0111, seg=1001111 ("1").
2. Scan timing: observe an across one frame.
   → Each slot is 4 cycles: 1 cycle of 1111, then 3 cycles of the one-hot-low pattern.
   → frame_done pulses once every 16 cycles.
3. Tear-free update: change bcd from 16'h1234 to 16'h9876 while digit==1.
   → The remaining slots of that frame still show 2,1.
   → The next frame shows 6,7,8,9 with seg 0100000, 0001111, 0000000, 0000100.
4. Illegal BCD and dp: drive bcd=16'hA0F5, dp_in=4'b0100.
   → Digits 3 and 1 show 1111110 (dash).
   → dp=0 only during the digit 2 slot.
5. Enable and async reset: drop en for 10 cycles, then pulse rst_n low mid-slot (digit 2).
   → During en=0, outputs are blanked while frame_done keeps its 16-cycle period.
   → On the reset pulse, outputs go to reset values without waiting for a clk edge, and scanning restarts from digit 0.
6. Leading-zero blanking (SEG_LZ_BLANK_EN defined): drive bcd=16'h0045.
   → Digits 3 and 2 show seg=1111111; digits 1 and 0 show "4" and "5".
   → With bcd=16'h0000, only digit 0 shows "0".
   → With the macro undefined, 16'h0045 shows 0,0,4,5.
